// File: rtl/hue_pkg.sv
// Shared constants, types and sideband payload for the RGB-to-hue pixel pipeline.
package hue_pkg;

  localparam int unsigned COLOR_DEPTH = 8;
  localparam int unsigned RGB_W       = 3 * COLOR_DEPTH;
  localparam int unsigned HUE_W       = COLOR_DEPTH;
  localparam int unsigned SAT_MIN     = 16;

  localparam int unsigned HUE_SECTOR  = 43;
  localparam logic [HUE_W-1:0] HUE_BASE_R = 8'd0;
  localparam logic [HUE_W-1:0] HUE_BASE_G = 8'd85;
  localparam logic [HUE_W-1:0] HUE_BASE_B = 8'd171;

  localparam int unsigned DIV_STAGES  = 6;
  localparam int unsigned LATENCY     = 9;

  localparam int unsigned DVD_W       = 14;
  localparam int unsigned DSR_W       = COLOR_DEPTH;
  localparam int unsigned QUO_W       = DIV_STAGES;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  typedef enum logic [1:0] {
    SEL_R,
    SEL_G,
    SEL_B
  } max_sel_e;

  // Per-pixel tags and hue-assembly fields carried alongside the divider
  typedef struct packed {
    logic             sof;
    logic             eof;
    logic             neg;
    logic             zero;
    logic [HUE_W-1:0] base;
  } side_t;

endpackage

// File: rtl/rgb_hue_stream_if.sv
// Pixel-in / hue-out stream bundle; master drives pixels, slave is the converter.
interface rgb_hue_stream_if;
  import hue_pkg::*;

  logic             in_valid;
  logic             in_sof;
  logic [RGB_W-1:0] in_rgb;
  logic             out_valid;
  logic [HUE_W-1:0] out_hue;
  logic             out_sof_pre;
  logic             out_eof;
  logic             frame_err;

  modport master (
    output in_valid, in_sof, in_rgb,
    input  out_valid, out_hue, out_sof_pre, out_eof, frame_err
  );

  modport slave (
    input  in_valid, in_sof, in_rgb,
    output out_valid, out_hue, out_sof_pre, out_eof, frame_err
  );

endinterface

// File: rtl/hue_div_pipe.sv
// Six-stage restoring divider, one quotient bit per stage, MSB first; valid and sideband ride along.
module hue_div_pipe
  import hue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_i,
  input  side_t            side_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DSR_W-1:0] divisor_i,
  output logic             vld_o,
  output side_t            side_o,
  output logic [QUO_W-1:0] quo_o
);

  logic [DIV_STAGES-1:0] vld_q;
  side_t                 side_q [DIV_STAGES];
  logic [QUO_W-1:0]      quo_q  [DIV_STAGES];
  logic [DVD_W-1:0]      rem_q  [DIV_STAGES-1];
  logic [DSR_W-1:0]      dsr_q  [DIV_STAGES-1];

  logic [DVD_W-1:0]      rem_in [DIV_STAGES];
  logic [DSR_W-1:0]      dsr_in [DIV_STAGES];
  logic [QUO_W-1:0]      quo_in [DIV_STAGES];
  logic [DVD_W-1:0]      trial  [DIV_STAGES];
  logic [DIV_STAGES-1:0] take;

  // Quotient is known to fit in QUO_W bits (|num| <= delta), so the first trial is divisor << (QUO_W-1)
  always_comb begin
    rem_in[0] = dividend_i;
    dsr_in[0] = divisor_i;
    quo_in[0] = '0;
    for (int i = 1; i < DIV_STAGES; i++) begin
      rem_in[i] = rem_q[i-1];
      dsr_in[i] = dsr_q[i-1];
      quo_in[i] = quo_q[i-1];
    end
    for (int i = 0; i < DIV_STAGES; i++) begin
      trial[i] = DVD_W'(dsr_in[i]) << (DIV_STAGES - 1 - i);
      take[i]  = (rem_in[i] >= trial[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DIV_STAGES; i++) begin
        side_q[i] <= '0;
        quo_q[i]  <= '0;
      end
      for (int i = 0; i < DIV_STAGES - 1; i++) begin
        rem_q[i] <= '0;
        dsr_q[i] <= '0;
      end
    end else begin
      vld_q     <= {vld_q[DIV_STAGES-2:0], vld_i};
      side_q[0] <= side_i;
      for (int i = 1; i < DIV_STAGES; i++) begin
        side_q[i] <= side_q[i-1];
      end
      for (int i = 0; i < DIV_STAGES; i++) begin
        quo_q[i] <= quo_in[i] | (QUO_W'(take[i]) << (DIV_STAGES - 1 - i));
      end
      for (int i = 0; i < DIV_STAGES - 1; i++) begin
        rem_q[i] <= take[i] ? (rem_in[i] - trial[i]) : rem_in[i];
        dsr_q[i] <= dsr_in[i];
      end
    end
  end

  assign vld_o  = vld_q[DIV_STAGES-1];
  assign side_o = side_q[DIV_STAGES-1];
  assign quo_o  = quo_q[DIV_STAGES-1];

endmodule

// File: rtl/rgb_hue_stream.sv
// Raster RGB to 8-bit hue converter, 1 pixel/clk, 9-cycle latency, frame tagging.
// Define LOW_SAT_GATE_EN to force hue 0 for pixels whose max-min is below SAT_MIN.
module rgb_hue_stream
  import hue_pkg::*;
#(
  parameter int unsigned WIDTH = 410,
  parameter int unsigned DEPTH = 361
) (
  input logic             clk,
  input logic             rst,
  rgb_hue_stream_if.slave bus
);

  localparam int unsigned PIX_N = WIDTH * DEPTH;
  localparam int unsigned CNT_W = $clog2(PIX_N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PIX_N - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic             s1_vld_q, s1_sof_q, s1_eof_q;
  logic [COLOR_DEPTH-1:0] s1_r_q, s1_g_q, s1_b_q, s1_max_q, s1_min_q;
  max_sel_e         s1_sel_q;

  logic             s2_vld_q;
  side_t            s2_side_q;
  logic [DVD_W-1:0] s2_dvd_q;
  logic [DSR_W-1:0] s2_dsr_q;

  logic             div_vld;
  side_t            div_side;
  logic [QUO_W-1:0] div_quo;

  logic             out_valid_q, out_eof_q;
  logic [HUE_W-1:0] out_hue_q;

  logic [CNT_W-1:0] pix_idx;
  logic             accept, is_last;
  logic [COLOR_DEPTH-1:0] in_r, in_g, in_b, in_max, in_min;
  max_sel_e         in_sel;

  // Accept decision, pixel index and channel extremes for the incoming pixel
  always_comb begin
    in_r    = bus.in_rgb[2*COLOR_DEPTH +: COLOR_DEPTH];
    in_g    = bus.in_rgb[COLOR_DEPTH   +: COLOR_DEPTH];
    in_b    = bus.in_rgb[0             +: COLOR_DEPTH];
    pix_idx = bus.in_sof ? '0 : cnt_q;
    accept  = bus.in_valid && ((state_q == ACTIVE) || bus.in_sof);
    is_last = (pix_idx == LAST);
    if (in_r >= in_g && in_r >= in_b) begin
      in_sel = SEL_R;
      in_max = in_r;
    end else if (in_g >= in_b) begin
      in_sel = SEL_G;
      in_max = in_g;
    end else begin
      in_sel = SEL_B;
      in_max = in_b;
    end
    in_min = (in_r <= in_g) ? in_r : in_g;
    if (in_b < in_min) in_min = in_b;
  end

  // Input FSM, pixel counter and S1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_sof_q <= 1'b0;
      s1_eof_q <= 1'b0;
      s1_r_q   <= '0;
      s1_g_q   <= '0;
      s1_b_q   <= '0;
      s1_max_q <= '0;
      s1_min_q <= '0;
      s1_sel_q <= SEL_R;
    end else begin
      err_q    <= bus.in_valid && bus.in_sof && (state_q == ACTIVE);
      s1_vld_q <= accept;
      s1_sof_q <= accept && bus.in_sof;
      s1_eof_q <= accept && is_last;
      s1_r_q   <= in_r;
      s1_g_q   <= in_g;
      s1_b_q   <= in_b;
      s1_max_q <= in_max;
      s1_min_q <= in_min;
      s1_sel_q <= in_sel;
      if (accept) begin
        state_q <= is_last ? IDLE : ACTIVE;
        cnt_q   <= is_last ? '0 : (pix_idx + CNT_W'(1));
      end
    end
  end

  logic [COLOR_DEPTH-1:0] s2_a, s2_b, s2_abs, s2_delta;
  logic [HUE_W-1:0]       s2_base;
  logic                   s2_neg, s2_zero;

  // Sector selection: num = a - b, with base hue of the dominant channel
  always_comb begin
    case (s1_sel_q)
      SEL_R:   begin s2_a = s1_g_q; s2_b = s1_b_q; s2_base = HUE_BASE_R; end
      SEL_G:   begin s2_a = s1_b_q; s2_b = s1_r_q; s2_base = HUE_BASE_G; end
      default: begin s2_a = s1_r_q; s2_b = s1_g_q; s2_base = HUE_BASE_B; end
    endcase
    s2_neg   = (s2_a < s2_b);
    s2_abs   = s2_neg ? (s2_b - s2_a) : (s2_a - s2_b);
    s2_delta = s1_max_q - s1_min_q;
`ifdef LOW_SAT_GATE_EN
    s2_zero  = (s2_delta < COLOR_DEPTH'(SAT_MIN));
`else
    s2_zero  = (s2_delta == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      s2_side_q <= '0;
      s2_dvd_q  <= '0;
      s2_dsr_q  <= '0;
    end else begin
      s2_vld_q  <= s1_vld_q;
      s2_side_q <= '{sof: s1_sof_q, eof: s1_eof_q, neg: s2_neg, zero: s2_zero, base: s2_base};
      s2_dvd_q  <= DVD_W'(s2_abs) * DVD_W'(HUE_SECTOR);
      s2_dsr_q  <= s2_delta;
    end
  end

  hue_div_pipe u_div (
    .clk        (clk),
    .rst        (rst),
    .vld_i      (s2_vld_q),
    .side_i     (s2_side_q),
    .dividend_i (s2_dvd_q),
    .divisor_i  (s2_dsr_q),
    .vld_o      (div_vld),
    .side_o     (div_side),
    .quo_o      (div_quo)
  );

  logic [HUE_W-1:0] s9_off, s9_hue;

  always_comb begin
    s9_off = HUE_W'(div_quo);
    if (div_side.neg) s9_off = -s9_off;
    s9_hue = div_side.zero ? '0 : (div_side.base + s9_off);
  end

  // S9 output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_hue_q   <= '0;
      out_eof_q   <= 1'b0;
    end else begin
      out_valid_q <= div_vld;
      out_hue_q   <= div_vld ? s9_hue : '0;
      out_eof_q   <= div_vld && div_side.eof;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_hue     = out_hue_q;
  assign bus.out_eof     = out_eof_q;
  assign bus.frame_err   = err_q;
  // S8 stage holds pixel 0 exactly one cycle before it leaves S9
  assign bus.out_sof_pre = div_vld && div_side.sof;

endmodule

// File: tb/tb_rgb_hue_stream.sv
// Self-checking bench for rgb_hue_stream with a 4x2 frame: directed table, frame-error, gaps, reset.
module tb_rgb_hue_stream;
  import hue_pkg::*;

  localparam int unsigned W    = 4;
  localparam int unsigned D    = 2;
  localparam int          N    = W * D;
  localparam int          LAT  = 9;
  localparam int          TMAX = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rgb_hue_stream_if bus ();

  rgb_hue_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [23:0] rgb;
    int          hue;
  } vec_t;

  logic       exp_v   [TMAX];
  logic [7:0] exp_h   [TMAX];
  logic       exp_sp  [TMAX];
  logic       exp_eof [TMAX];
  logic       exp_err [TMAX];

  int step_n, checks, errors;
  bit m_active;
  int m_cnt;

  function automatic int ref_hue(input logic [23:0] rgb);
    int r, g, b, mx, mn, num, base, q, h;
    r = int'(rgb[23:16]); g = int'(rgb[15:8]); b = int'(rgb[7:0]);
    if (r >= g && r >= b) begin mx = r; num = g - b; base = 0; end
    else if (g >= b)      begin mx = g; num = b - r; base = 85; end
    else                  begin mx = b; num = r - g; base = 171; end
    mn = (r < g) ? r : g;
    if (b < mn) mn = b;
    if (mx == mn) return 0;
`ifdef LOW_SAT_GATE_EN
    if (mx - mn < 16) return 0;
`endif
    q = (43 * ((num < 0) ? -num : num)) / (mx - mn);
    h = (num < 0) ? base - q : base + q;
    return (h + 256) % 256;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", name, step_n, act, req);
    end
  endtask

  task automatic clear_exp(input int from);
    for (int t = from; t < TMAX; t++) begin
      exp_v[t] = 1'b0; exp_h[t] = '0; exp_sp[t] = 1'b0; exp_eof[t] = 1'b0; exp_err[t] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    step_n++;
    if (step_n + LAT + 1 >= TMAX) begin
      $display("FAIL step_budget: got %0d steps, expected fewer than %0d", step_n, TMAX - LAT - 1);
      $fatal(1);
    end
    chk("out_valid", int'(bus.out_valid), int'(exp_v[step_n]));
    if (exp_v[step_n]) chk("out_hue", int'(bus.out_hue), int'(exp_h[step_n]));
    chk("out_sof_pre", int'(bus.out_sof_pre), int'(exp_sp[step_n]));
    chk("out_eof", int'(bus.out_eof), int'(exp_eof[step_n]));
    chk("frame_err", int'(bus.frame_err), int'(exp_err[step_n]));
  endtask

  // Applies one input cycle and records what the outputs must show later
  task automatic drive(input bit v, input bit sof, input logic [23:0] rgb, input int hue);
    int idx;
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_rgb   = rgb;
    if (v && sof && m_active) exp_err[step_n + 1] = 1'b1;
    if (v && (m_active || sof)) begin
      idx = sof ? 0 : m_cnt;
      exp_v[step_n + LAT] = 1'b1;
      exp_h[step_n + LAT] = 8'(hue);
      if (sof) exp_sp[step_n + LAT - 1] = 1'b1;
      if (idx == N - 1) begin
        exp_eof[step_n + LAT] = 1'b1;
        m_active = 1'b0;
        m_cnt    = 0;
      end else begin
        m_active = 1'b1;
        m_cnt    = idx + 1;
      end
    end
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 24'($urandom()), 0);
  endtask

  task automatic rand_pix(input bit sof);
    logic [23:0] rgb;
    rgb = 24'($urandom());
    drive(1'b1, sof, rgb, ref_hue(rgb));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl [N];
    tbl[0] = '{24'hFF0000, 0};
    tbl[1] = '{24'h00FF00, 85};
    tbl[2] = '{24'h0000FF, 171};
    tbl[3] = '{24'hFFFF00, 43};
    tbl[4] = '{24'hFF0080, 235};
    tbl[5] = '{24'h808080, 0};
    tbl[6] = '{24'h645A5A, 0};
    tbl[7] = '{24'h0080FF, 150};

    step_n = 0; checks = 0; errors = 0; m_active = 1'b0; m_cnt = 0;
    clear_exp(0);
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_rgb = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle(2);

    // Directed gapless frame, then non-sof pixels in IDLE must be dropped
    for (int i = 0; i < N; i++) drive(1'b1, (i == 0), tbl[i].rgb, tbl[i].hue);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, tbl[i].rgb, tbl[i].hue);
    idle(LAT + 1);

    // sof at index 3 restarts the frame; then back-to-back frames with random gaps
    rand_pix(1'b1);
    rand_pix(1'b0);
    rand_pix(1'b0);
    rand_pix(1'b1);
    for (int i = 0; i < N - 1; i++) rand_pix(1'b0);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        if (i != 0 && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        rand_pix(i == 0);
      end
    end
    idle(LAT + 1);

    // Reset with the pipeline full mid-frame
    rand_pix(1'b1);
    for (int i = 0; i < N - 2; i++) rand_pix(1'b0);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_hue", int'(bus.out_hue), 0);
    chk("rst_out_sof_pre", int'(bus.out_sof_pre), 0);
    chk("rst_out_eof", int'(bus.out_eof), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    clear_exp(step_n + 1);
    m_active = 1'b0;
    m_cnt    = 0;
    idle(2);
    rst = 1'b0;
    idle(LAT + 2);
    rand_pix(1'b0);
    for (int i = 0; i < N; i++) rand_pix(i == 0);
    idle(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
